// File: rtl/histogram_pkg.sv
// Constants and controller state type shared by the histogram memory, its
// readout path and the update controller.
package histogram_pkg;

   localparam int unsigned HIST_ADDR_W = 10;
   localparam int unsigned HIST_DATA_W = 16;

   typedef enum logic [2:0] {
      StIdle,
      StRd1,
      StRd2,
      StWr,
      StClr
   } histState_t;

endpackage

// File: rtl/histogram_update_controller.sv
// Drives port A of the histogram BRAM: saturating read-modify-write increments
// for accepted bin events, and a full-memory clear sweep on request.
module histogram_update_controller
   import histogram_pkg::*;
#(
   parameter int unsigned ADDR_W = HIST_ADDR_W,
   parameter int unsigned DATA_W = HIST_DATA_W,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              evt_valid,
   input  logic [ADDR_W-1:0] evt_bin,
   output logic              evt_ready,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [CNT_W-1:0]  evt_count,
   output logic              saturated
);

   localparam logic [DATA_W-1:0] FullScale = '1;
   localparam logic [ADDR_W-1:0] LastAddr  = '1;
   localparam logic [CNT_W-1:0]  CountMax  = '1;

   histState_t state;
   logic       clearPending;
   logic       accept;
   logic       willSaturate;

   // Ready is a pure decode of registered state so no combinational path exists from evt_valid.
   assign evt_ready    = ((state == StIdle) || (state == StWr)) && !clearPending;
   assign clear_busy   = clearPending || (state == StClr);
   assign accept       = evt_valid && evt_ready;
   assign willSaturate = (mem_dout == FullScale) || (mem_dout == FullScale - DATA_W'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= StIdle;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         evt_count    <= '0;
         saturated    <= 1'b0;
         clearPending <= 1'b0;
      end else begin
         if (clear_start && (state != StClr)) begin
            clearPending <= 1'b1;
         end

         unique case (state)
            StIdle, StWr: begin
               if (accept) begin
                  mem_addr <= evt_bin;
                  mem_we   <= 1'b0;
                  state    <= StRd1;
                  if (evt_count != CountMax) begin
                     evt_count <= evt_count + CNT_W'(1);
                  end
               end else if (clearPending) begin
                  // Entry overrides a clear_start arriving on this same edge.
                  mem_addr     <= '0;
                  mem_din      <= '0;
                  mem_we       <= 1'b1;
                  clearPending <= 1'b0;
                  state        <= StClr;
               end else begin
                  mem_we <= 1'b0;
                  state  <= StIdle;
               end
            end

            StRd1: state <= StRd2;

            StRd2: begin
               mem_din <= (mem_dout == FullScale) ? FullScale : mem_dout + DATA_W'(1);
               mem_we  <= 1'b1;
               if (willSaturate) begin
                  saturated <= 1'b1;
               end
               state <= StWr;
            end

            StClr: begin
               if (mem_addr == LastAddr) begin
                  mem_we    <= 1'b0;
                  evt_count <= '0;
                  saturated <= 1'b0;
                  state     <= StIdle;
               end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_histogram_update_controller.sv
// Directed bench for histogram_update_controller with a behavioural 1-cycle-latency
// BRAM on port A.
module tb_histogram_update_controller;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          evt_valid = 1'b0;
   logic [AW-1:0] evt_bin = '0;
   logic          evt_ready;
   logic          clear_start = 1'b0;
   logic          clear_busy;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic [CW-1:0] evt_count;
   logic          saturated;

   logic [DW-1:0] bram [0:(1<<AW)-1];
   logic          preEn = 1'b0;
   logic [AW-1:0] preAddr = '0;
   logic [DW-1:0] preData = '0;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   histogram_update_controller dut (
      .clk        (clk),
      .reset      (reset),
      .evt_valid  (evt_valid),
      .evt_bin    (evt_bin),
      .evt_ready  (evt_ready),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .evt_count  (evt_count),
      .saturated  (saturated)
   );

   // Read-first port A; preload port lets the bench seed bins while the DUT is idle.
   always @(posedge clk) begin
      if (preEn) bram[preAddr] <= preData;
      else if (mem_we) bram[mem_addr] <= mem_din;
      mem_dout <= bram[mem_addr];
   end

   typedef struct {
      logic [AW-1:0] bin;
      logic [DW-1:0] preload;
      logic [DW-1:0] expDin;
      logic          expSat;
      logic [CW-1:0] expCount;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      preEn = 1'b1; preAddr = a; preData = d;
      tick();
      preEn = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Issues one event and returns positioned in the WR cycle (two edges after accept).
   task automatic sendEvent(input logic [AW-1:0] b);
      int wait_n = 0;
      evt_valid = 1'b1;
      evt_bin   = b;
      while (!evt_ready && wait_n < 2000) begin
         tick();
         wait_n++;
      end
      if (!evt_ready) check("evt_ready_timeout", 32'(evt_ready), 32'd1);
      tick();
      evt_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int accCyc [3];
      int nAcc;
      int badSweep;
      int nonZero;
      int wait_n;

      for (int i = 0; i < (1 << AW); i++) bram[i] = '0;

      vecs[0] = '{bin: 10'd5,    preload: 16'd7,      expDin: 16'd8,      expSat: 1'b0, expCount: 32'd1};
      vecs[1] = '{bin: 10'd0,    preload: 16'd0,      expDin: 16'd1,      expSat: 1'b0, expCount: 32'd2};
      vecs[2] = '{bin: 10'd1023, preload: 16'h1234,   expDin: 16'h1235,   expSat: 1'b0, expCount: 32'd3};
      vecs[3] = '{bin: 10'd9,    preload: 16'hFFFF,   expDin: 16'hFFFF,   expSat: 1'b1, expCount: 32'd4};
      vecs[4] = '{bin: 10'd10,   preload: 16'hFFFE,   expDin: 16'hFFFF,   expSat: 1'b1, expCount: 32'd5};
      vecs[5] = '{bin: 10'd7,    preload: 16'd3,      expDin: 16'd4,      expSat: 1'b1, expCount: 32'd6};

      doReset();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_evt_count", evt_count, 32'd0);
      check("rst_saturated", 32'(saturated), 32'd0);
      check("rst_evt_ready", 32'(evt_ready), 32'd1);
      check("rst_clear_busy", 32'(clear_busy), 32'd0);

      // Single events through the table; saturated is sticky once set.
      for (int i = 0; i < 6; i++) begin
         preload(vecs[i].bin, vecs[i].preload);
         sendEvent(vecs[i].bin);
         check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'd1);
         check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].bin));
         check($sformatf("v%0d_mem_din", i), 32'(mem_din), 32'(vecs[i].expDin));
         check($sformatf("v%0d_evt_count", i), evt_count, vecs[i].expCount);
         check($sformatf("v%0d_saturated", i), 32'(saturated), 32'(vecs[i].expSat));
         tick();
         check($sformatf("v%0d_bin_value", i), 32'(bram[vecs[i].bin]), 32'(vecs[i].expDin));
         check($sformatf("v%0d_back_idle_we", i), 32'(mem_we), 32'd0);
      end

      // Clear from IDLE with counters non-zero.
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check("clr_busy_next", 32'(clear_busy), 32'd1);
      check("clr_ready_pending", 32'(evt_ready), 32'd0);
      badSweep = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         tick();
         if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_din !== '0 || evt_ready !== 1'b0
             || clear_busy !== 1'b1) begin
            if (badSweep == 0)
               $display("FAIL clr_sweep_step%0d: we=%0b addr=%0d din=%0h ready=%0b, expected we=1 addr=%0d din=0 ready=0",
                        i, mem_we, mem_addr, mem_din, evt_ready, i);
            badSweep++;
         end
      end
      nChecks++;
      if (badSweep != 0) nErrors++;
      tick();
      check("clr_done_we", 32'(mem_we), 32'd0);
      check("clr_done_busy", 32'(clear_busy), 32'd0);
      check("clr_done_count", evt_count, 32'd0);
      check("clr_done_sat", 32'(saturated), 32'd0);
      check("clr_done_ready", 32'(evt_ready), 32'd1);
      nonZero = 0;
      for (int i = 0; i < (1 << AW); i++) if (bram[i] != '0) nonZero++;
      check("clr_mem_zero", 32'(nonZero), 32'd0);

      // Back-to-back events to bin 3 with evt_valid held high.
      doReset();
      preload(10'd3, 16'd0);
      evt_valid = 1'b1;
      evt_bin   = 10'd3;
      nAcc = 0;
      for (int c = 0; c < 9; c++) begin
         if (evt_valid && evt_ready && nAcc < 3) begin
            accCyc[nAcc] = c;
            nAcc++;
         end
         tick();
         if (nAcc == 3) evt_valid = 1'b0;
      end
      check("b2b_accepts", 32'(nAcc), 32'd3);
      check("b2b_acc1_cycle", 32'(accCyc[1]), 32'd3);
      check("b2b_acc2_cycle", 32'(accCyc[2]), 32'd6);
      tick();
      tick();
      check("b2b_bin3", 32'(bram[3]), 32'd3);
      check("b2b_count", evt_count, 32'd3);

      // clear_start coincident with an accepted event: event completes, then sweep.
      preload(10'd2, 16'd4);
      evt_valid   = 1'b1;
      evt_bin     = 10'd2;
      clear_start = 1'b1;
      tick();
      evt_valid   = 1'b0;
      clear_start = 1'b0;
      check("coin_busy", 32'(clear_busy), 32'd1);
      check("coin_ready", 32'(evt_ready), 32'd0);
      tick();
      tick();
      check("coin_wr_we", 32'(mem_we), 32'd1);
      check("coin_wr_addr", 32'(mem_addr), 32'd2);
      check("coin_wr_din", 32'(mem_din), 32'd5);
      tick();
      check("coin_bin2_written", 32'(bram[2]), 32'd5);
      check("coin_clr_entry_addr", 32'(mem_addr), 32'd0);
      check("coin_clr_entry_we", 32'(mem_we), 32'd1);
      wait_n = 0;
      while (clear_busy && wait_n < 1100) begin
         tick();
         wait_n++;
      end
      check("coin_clr_finished", 32'(clear_busy), 32'd0);
      check("coin_bin2_final", 32'(bram[2]), 32'd0);
      check("coin_count", evt_count, 32'd0);

      // Reset during RD2: no write, outputs cleared, next event normal.
      preload(10'd6, 16'd20);
      evt_valid = 1'b1;
      evt_bin   = 10'd6;
      tick();
      evt_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("rd2rst_we", 32'(mem_we), 32'd0);
      check("rd2rst_addr", 32'(mem_addr), 32'd0);
      check("rd2rst_din", 32'(mem_din), 32'd0);
      check("rd2rst_count", evt_count, 32'd0);
      check("rd2rst_sat", 32'(saturated), 32'd0);
      tick();
      check("rd2rst_bin6_kept", 32'(bram[6]), 32'd20);
      reset = 1'b1;
      sendEvent(10'd6);
      check("rd2rst_next_din", 32'(mem_din), 32'd21);
      check("rd2rst_next_count", evt_count, 32'd1);
      tick();
      check("rd2rst_bin6_final", 32'(bram[6]), 32'd21);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
